flashrom_arbiter: RTL and testbench

Two-port read arbiter and sequencer for the 128-byte on-chip FlashROM. It accepts byte-read requests from two independent requesters (port 0: bus slave, port 1: boot-time config loader), grants one at a time, drives the ROM address, waits out the ROM's synchronous read latency, and returns the byte to the granted port with a one-cycle valid strobe. It sits directly between the requesters and `flashrom_infrastructure`.

---
 rtl/flashrom_arbiter_pkg.sv | 23 ++
 rtl/flashrom_arbiter_if.sv | 33 +++
 rtl/flashrom_arbiter_rr_grant.sv | 30 +++
 rtl/flashrom_arbiter.sv | 108 ++++++++++
 tb/tb_flashrom_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flashrom_arbiter_pkg.sv
// Shared types and constants for the FlashROM two-port read arbiter.
// Used by the grant logic, the top-level sequencer and the bench.
package flashrom_arb_pkg;

    localparam int ROM_ADDR_W      = 7;
    localparam int ROM_DATA_W      = 8;
    localparam int ROM_LATENCY_DEF = 2;
    localparam int LAT_CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    typedef logic port_idx_t;

    function automatic port_idx_t other_port(port_idx_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/flashrom_arbiter_if.sv
// Requester and ROM-side signals of the FlashROM arbiter.
// slave: arbiter side; master: requesters plus ROM model side.
interface flashrom_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);

    logic              REQ0;
    logic              REQ1;
    logic [ADDR_W-1:0] ADDR0;
    logic [ADDR_W-1:0] ADDR1;
    logic              ACK0;
    logic              ACK1;
    logic              VALID0;
    logic              VALID1;
    logic [DATA_W-1:0] DATA0;
    logic [DATA_W-1:0] DATA1;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [DATA_W-1:0] ROM_DOUT;

    modport slave (
        input  REQ0, REQ1, ADDR0, ADDR1, ROM_DOUT,
        output ACK0, ACK1, VALID0, VALID1,
        output DATA0, DATA1, ROM_ADDR
    );

    modport master (
        output REQ0, REQ1, ADDR0, ADDR1, ROM_DOUT,
        input  ACK0, ACK1, VALID0, VALID1,
        input  DATA0, DATA1, ROM_ADDR
    );

endinterface

// File: rtl/flashrom_arbiter_rr_grant.sv
// Combinational two-way grant for the FlashROM arbiter.
// FLASHROM_ARB_FIXED_PRIORITY_EN: port 0 wins ties, no last-grant input.
module flashrom_rr_grant
    import flashrom_arb_pkg::*;
(
    input  logic      req0_i,
    input  logic      req1_i,
`ifndef FLASHROM_ARB_FIXED_PRIORITY_EN
    input  port_idx_t last_i,
`endif
    output logic      gnt_vld_o,
    output port_idx_t gnt_o
);

    // Pick a port: lone requester wins, ties resolved by policy.
    always_comb begin
        gnt_vld_o = req0_i | req1_i;
        gnt_o     = 1'b0;
        if (req0_i && req1_i) begin
`ifdef FLASHROM_ARB_FIXED_PRIORITY_EN
            gnt_o = 1'b0;
`else
            gnt_o = other_port(last_i);
`endif
        end else if (req1_i) begin
            gnt_o = 1'b1;
        end
    end

endmodule

// File: rtl/flashrom_arbiter.sv
// Two-port byte-read arbiter and sequencer in front of the FlashROM.
// Optional FLASHROM_ARB_FIXED_PRIORITY_EN selects fixed port-0 priority.
module flashrom_arbiter
    import flashrom_arb_pkg::*;
#(
    parameter int ADDR_W      = ROM_ADDR_W,
    parameter int DATA_W      = ROM_DATA_W,
    parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    flashrom_arbiter_if.slave bus
);

    arb_state_e           state_q;
    port_idx_t            gnt_q;
    port_idx_t            gnt_d;
    logic                 gnt_vld_d;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic                 ack0_q;
    logic                 ack1_q;
    logic                 valid0_q;
    logic                 valid1_q;
    logic [DATA_W-1:0]    data0_q;
    logic [DATA_W-1:0]    data1_q;
    logic [ADDR_W-1:0]    rom_addr_q;
`ifndef FLASHROM_ARB_FIXED_PRIORITY_EN
    port_idx_t            last_q;
`endif

    flashrom_rr_grant u_grant (
        .req0_i    (bus.REQ0),
        .req1_i    (bus.REQ1),
`ifndef FLASHROM_ARB_FIXED_PRIORITY_EN
        .last_i    (last_q),
`endif
        .gnt_vld_o (gnt_vld_d),
        .gnt_o     (gnt_d)
    );

    // Sequencer: arbitrate, issue address, wait ROM latency, return byte.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            rom_addr_q <= '0;
`ifndef FLASHROM_ARB_FIXED_PRIORITY_EN
            last_q     <= 1'b1;
`endif
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q      <= gnt_d;
                        rom_addr_q <= gnt_d ? bus.ADDR1 : bus.ADDR0;
                        ack0_q     <= ~gnt_d;
                        ack1_q     <= gnt_d;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= LAT_CNT_W'(ROM_LATENCY - 1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        if (gnt_q) begin
                            data1_q  <= bus.ROM_DOUT;
                            valid1_q <= 1'b1;
                        end else begin
                            data0_q  <= bus.ROM_DOUT;
                            valid0_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
`ifndef FLASHROM_ARB_FIXED_PRIORITY_EN
                    last_q <= gnt_q;
`endif
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ACK0     = ack0_q;
    assign bus.ACK1     = ack1_q;
    assign bus.VALID0   = valid0_q;
    assign bus.VALID1   = valid1_q;
    assign bus.DATA0    = data0_q;
    assign bus.DATA1    = data1_q;
    assign bus.ROM_ADDR = rom_addr_q;

endmodule

// File: tb/tb_flashrom_arbiter.sv
// Scoreboard bench for flashrom_arbiter: three DUTs (latency 2, 1, 7).
// Stimulus pushes expected strobes; one negedge monitor pops and checks.
module tb_flashrom_arbiter;

    typedef struct {
        int         port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        int         tag;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] ra;
        logic [3:0] strb;
    } snap_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    int         cyc = 0;
    logic [7:0] mem [128];

    logic [2:0] req0 = '0;
    logic [2:0] req1 = '0;
    logic [2:0] ack0;
    logic [2:0] ack1;
    logic [2:0] vld0;
    logic [2:0] vld1;
    logic [6:0] addr0 [3];
    logic [6:0] addr1 [3];
    logic [6:0] raddr [3];
    logic [7:0] data0 [3];
    logic [7:0] data1 [3];

    exp_t  aq [3][$];
    exp_t  vq [3][$];
    snap_t snq [$];

    int   checks = 0;
    int   errors = 0;
    int   tmo = 0;
    logic fin_req = 1'b0;
    logic fin_done = 1'b0;
    logic [7:0] l0 [3];
    logic [7:0] l1 [3];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
        flashrom_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();
        logic [7:0] pipe [L];

        assign bus.REQ0  = req0[g];
        assign bus.REQ1  = req1[g];
        assign bus.ADDR0 = addr0[g];
        assign bus.ADDR1 = addr1[g];
        assign ack0[g]   = bus.ACK0;
        assign ack1[g]   = bus.ACK1;
        assign vld0[g]   = bus.VALID0;
        assign vld1[g]   = bus.VALID1;
        assign data0[g]  = bus.DATA0;
        assign data1[g]  = bus.DATA1;
        assign raddr[g]  = bus.ROM_ADDR;
        assign bus.ROM_DOUT = pipe[L-1];

        always @(posedge CLK) begin
            pipe[0] <= mem[bus.ROM_ADDR];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end

        flashrom_arbiter #(
            .ADDR_W      (7),
            .DATA_W      (8),
            .ROM_LATENCY (L)
        ) dut (
            .CLK (CLK),
            .RST (RST),
            .bus (bus)
        );
    end

    always @(negedge CLK) begin
        while (snq.size() != 0) begin
            snap_t s;
            logic [3:0] st;
            s  = snq.pop_front();
            st = {ack0[0], ack1[0], vld0[0], vld1[0]};
            checks++;
            if (data0[0] !== s.d0 || data1[0] !== s.d1 ||
                raddr[0] !== s.ra || st !== s.strb) begin
                errors++;
                $display("FAIL snap%0d got d0=%h d1=%h ra=%h strb=%b want d0=%h d1=%h ra=%h strb=%b",
                         s.tag, data0[0], data1[0], raddr[0], st,
                         s.d0, s.d1, s.ra, s.strb);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                l0[i] = data0[i];
                l1[i] = data1[i];
            end else begin
                int n;
                n = int'(ack0[i]) + int'(ack1[i]) + int'(vld0[i]) + int'(vld1[i]);
                if (n > 0) begin
                    checks++;
                    if (n > 1) begin
                        errors++;
                        $display("FAIL overlap inst%0d cyc %0d got %0d strobes want 1", i, cyc, n);
                    end
                end
                if (ack0[i] || ack1[i]) begin
                    int p;
                    p = ack1[i] ? 1 : 0;
                    if (aq[i].size() == 0) begin
                        errors++;
                        $display("FAIL ack_unexp inst%0d cyc %0d got port %0d want none", i, cyc, p);
                    end else begin
                        exp_t e;
                        e = aq[i].pop_front();
                        if (e.port != p || e.cyc != cyc) begin
                            errors++;
                            $display("FAIL ack inst%0d got port %0d cyc %0d want port %0d cyc %0d",
                                     i, p, cyc, e.port, e.cyc);
                        end
                    end
                end
                if (vld0[i] || vld1[i]) begin
                    int p;
                    logic [7:0] d;
                    p = vld1[i] ? 1 : 0;
                    d = vld1[i] ? data1[i] : data0[i];
                    if (vq[i].size() == 0) begin
                        errors++;
                        $display("FAIL valid_unexp inst%0d cyc %0d got port %0d want none", i, cyc, p);
                    end else begin
                        exp_t e;
                        e = vq[i].pop_front();
                        if (e.port != p || e.cyc != cyc || e.data !== d) begin
                            errors++;
                            $display("FAIL valid inst%0d got port %0d data %h cyc %0d want port %0d data %h cyc %0d",
                                     i, p, d, cyc, e.port, e.data, e.cyc);
                        end
                    end
                end
                if (!vld0[i] && data0[i] !== l0[i]) begin
                    errors++;
                    $display("FAIL data0_hold inst%0d got %h want %h", i, data0[i], l0[i]);
                end
                if (!vld1[i] && data1[i] !== l1[i]) begin
                    errors++;
                    $display("FAIL data1_hold inst%0d got %h want %h", i, data1[i], l1[i]);
                end
                l0[i] = data0[i];
                l1[i] = data1[i];
            end
        end
        if (fin_req && !fin_done) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aq[i].size() != 0 || vq[i].size() != 0) begin
                    errors++;
                    $display("FAIL leftover inst%0d got acks %0d valids %0d want 0 0",
                             i, aq[i].size(), vq[i].size());
                end
            end
            checks++;
            if (tmo != 0) begin
                errors++;
                $display("FAIL timeouts got %0d want 0", tmo);
            end
            fin_done = 1'b1;
        end
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_cyc(int n);
        while (cyc < n) step(1);
    endtask

    task automatic drain(int k);
        int b;
        b = 0;
        while ((vq[k].size() != 0 || aq[k].size() != 0) && b < 40) begin
            step(1);
            b++;
        end
        if (b >= 40) begin
            $display("FAIL drain inst%0d timeout got %0d pending want 0", k, vq[k].size());
            tmo++;
        end
    endtask

    task automatic snap(int tag, logic [7:0] d0, logic [7:0] d1, logic [6:0] ra);
        snap_t s;
        s.tag  = tag;
        s.d0   = d0;
        s.d1   = d1;
        s.ra   = ra;
        s.strb = 4'b0000;
        snq.push_back(s);
    endtask

    task automatic rd(int k, int p, logic [6:0] a);
        int c;
        c = cyc;
        if (p == 0) begin
            req0[k]  = 1'b1;
            addr0[k] = a;
        end else begin
            req1[k]  = 1'b1;
            addr1[k] = a;
        end
        aq[k].push_back('{p, 8'h00, c + 1});
        vq[k].push_back('{p, mem[a], c + lat_of(k) + 2});
        step(1);
        req0[k] = 1'b0;
        req1[k] = 1'b0;
        drain(k);
    endtask

    initial begin
        int c;
        int p;
        logic [7:0] exp_d1;
        logic [6:0] exp_ra;
        for (int a = 0; a < 128; a++) mem[a] = 8'((a * 29 + 7) ^ 8'hC3);
        mem[7'h15] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            addr0[i] = '0;
            addr1[i] = '0;
        end
        RST = 1'b1;
        step(3);
        RST = 1'b0;
        step(1);
        snap(1, 8'h00, 8'h00, 7'h00);
        step(1);

        rd(0, 0, 7'h15);
        snap(2, 8'h5A, 8'h00, 7'h15);
        step(2);

        c = cyc;
        req1[0]  = 1'b1;
        addr1[0] = 7'h40;
        aq[0].push_back('{1, 8'h00, c + 1});
        step(1);
        req1[0] = 1'b0;
        step(1);
        RST = 1'b1;
        step(1);
        snap(3, 8'h00, 8'h00, 7'h00);
        step(1);
        RST = 1'b0;
        step(6);
        snap(4, 8'h00, 8'h00, 7'h00);
        step(1);

        rd(0, 1, 7'h40);
        snap(5, 8'h00, mem[7'h40], 7'h40);
        step(2);

        c = cyc;
        req0[0]  = 1'b1;
        addr0[0] = 7'h00;
        req1[0]  = 1'b1;
        addr1[0] = 7'h7F;
        for (int k = 0; k < 4; k++) begin
`ifdef FLASHROM_ARB_FIXED_PRIORITY_EN
            p = 0;
`else
            p = k % 2;
`endif
            aq[0].push_back('{p, 8'h00, c + 1 + 5 * k});
            vq[0].push_back('{p, (p == 1) ? mem[7'h7F] : mem[7'h00], c + 4 + 5 * k});
        end
        wait_cyc(c + 17);
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        drain(0);
`ifdef FLASHROM_ARB_FIXED_PRIORITY_EN
        exp_d1 = mem[7'h40];
        exp_ra = 7'h00;
`else
        exp_d1 = mem[7'h7F];
        exp_ra = 7'h7F;
`endif
        snap(6, mem[7'h00], exp_d1, exp_ra);
        step(2);

        c = cyc;
        req0[0]  = 1'b1;
        addr0[0] = 7'h2A;
        req1[0]  = 1'b1;
        addr1[0] = 7'h33;
        aq[0].push_back('{0, 8'h00, c + 1});
        vq[0].push_back('{0, mem[7'h2A], c + 4});
        step(1);
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        drain(0);
        step(4);
        snap(7, mem[7'h2A], exp_d1, 7'h2A);
        step(1);

        for (int k = 1; k < 3; k++) begin
            for (int a = 0; a < 128; a++) rd(k, 1, 7'(a));
        end
        step(2);

        fin_req = 1'b1;
        step(2);
        if (!fin_done) $display("FAIL final_checks got not_done want done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
